serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-in, serial-out frame transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line as start bit, data LSB-first, optional even parity, then stop bit.
- It is the sending end of the one-wire serial link. The matching receiver samples the line with the team's flip-flop primitives.
- It sits between the datapath output register and the serial link pin.

Parameters:
WIDTH, 8, data bits per frame (1..32)
CLKS_PER_BIT, 4, clock cycles each bit is held on tx_line (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  WIDTH  word to transmit; sampled only on the handshake cycle
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  transmitter can accept a word this cycle
tx_line  output  1  serial line; idles high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: when reset is high at a rising edge, the block goes to IDLE. All counters clear, shift register clears, tx_line=1, tx_ready=1, busy=0, done=0. Reset overrides everything, including mid-frame. An aborted frame is dropped; no partial stop bit is emitted.
- All outputs are registered or decoded from registered state only. There is no combinational path from tx_valid or tx_data to any output.
- FSM states:
  - IDLE: tx_line=1, tx_ready=1, busy=0. If tx_valid&tx_ready at an edge, latch tx_data into the shift register, compute parity=^tx_data, and go to START.
  - START: tx_line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_line=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index. After bit WIDTH-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_line=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles, then return to IDLE. done=1 in the first IDLE cycle only.
- tx_ready=0 and busy=1 in every state except IDLE.
- Back-to-back frames: tx_valid held high is accepted in the same cycle done is high. The next START begins the following cycle, so exactly one idle-high cycle separates frames.
- Latency: the start bit appears on tx_line 1 cycle after the handshake edge.
- Frame length from first START cycle to last STOP cycle is CLKS_PER_BIT*(WIDTH+2+PARITY_EN) cycles.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide and wraps from CLKS_PER_BIT-1 to 0. CLKS_PER_BIT=1 is legal and gives one cycle per bit.
- The bit index is ceil(log2(WIDTH+1)) bits wide.
- tx_data changes while busy are ignored.
- tx_valid asserted during reset is not accepted.

Test Plan:
- Reset then idle (reset high 3 cycles, tx_valid=0) -> tx_line=1, tx_ready=1, busy=0, done=0 on every cycle.
- WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> tx_line per 4-cycle bit is 0 | 1,0,1,0,0,1,0,1 | 0 | 1. That is 44 cycles total. busy is high for 44 cycles, done pulses at cycle 45, and tx_ready is low throughout the frame.
- Same config, send 0x07 -> parity bit=1. A receiver model rebuilding the frame sees 0x07 and correct parity.
- Back-to-back: tx_valid held high with 0x3C then 0xC3 -> second handshake in the done cycle. Exactly one high cycle between the first stop bit and the second start bit, and both words are decoded correctly.
- Reset mid-frame: assert reset during data bit 3 of 0xFF -> next cycle tx_line=1, tx_ready=1, busy=0, no done pulse. A new word 0x5A sent afterwards is transmitted intact.
- PARITY_EN=0, CLKS_PER_BIT=1, send 0x80 -> frame is 0,0,0,0,0,0,0,0,1,1 over 10 cycles, done on cycle 11.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-in serial-out frame transmitter (start, data LSB-first, optional even parity, stop)
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_line,
  output logic             busy,
  output logic             done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH + 1) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] shift;
  logic par, bit_end, last_bit;
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_bit = idx == IW'(WIDTH - 1);
  assign tx_ready = state == IDLE;
  assign busy     = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = tx_valid ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = !(bit_end && last_bit) ? DATA : (PARITY_EN != 0 ? PARITY : STOP);
      PARITY:  state_n = bit_end ? STOP : PARITY;
      default: state_n = bit_end ? IDLE : STOP;
    endcase
  end
  always_comb begin
    tx_line = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == STOP && bit_end;
      if (state == IDLE) begin
        cnt <= '0;
        idx <= '0;
        if (tx_valid) begin
          shift <= tx_data;
          par   <= ^tx_data;
        end
      end else begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if (state == DATA && bit_end) begin
          shift <= shift >> 1;
          idx   <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and random frames on two configurations, checked against a frame-level model
module tb_serial_tx;
  logic clk = 0, reset = 1;
  logic v0 = 0, v1 = 0;
  logic [7:0] d0 = 0, d1 = 0;
  logic ready0, line0, busy0, done0, ready1, line1, busy1, done1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
    .tx_ready(ready0), .tx_line(line0), .busy(busy0), .done(done0));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
    .tx_ready(ready1), .tx_line(line1), .busy(busy1), .done(done1));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk_out(input int sel, input string tag, input logic l, input logic r, input logic b, input logic d);
    chk({tag, "_line"}, sel ? line1 : line0, l);
    chk({tag, "_ready"}, sel ? ready1 : ready0, r);
    chk({tag, "_busy"}, sel ? busy1 : busy0, b);
    chk({tag, "_done"}, sel ? done1 : done0, d);
  endtask
  // Frame bit k: start, data LSB-first, optional even parity, stop
  function automatic logic exp_bit(input logic [7:0] w, input int k, input int pe);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
    if (pe != 0 && k == 9) return ^w;
    return 1'b1;
  endfunction
  // Called at a negedge with the DUT ready; returns at the negedge of the done cycle
  task automatic frame(input int sel, input logic [7:0] w, input bit hold, input int abort_at);
    int cpb = sel ? 1 : 4;
    int pe = sel ? 0 : 1;
    int nb = 10 + pe;
    logic [7:0] rx = 0;
    logic l;
    if (sel != 0) begin v1 = 1; d1 = w; end else begin v0 = 1; d0 = w; end
    @(negedge clk);
    if (!hold) begin v0 = 0; v1 = 0; end
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    for (int c = 0; c < cpb * nb; c++) begin
      if (c == abort_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_out(sel, "abort", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_out(sel, "abort_after", 1'b1, 1'b1, 1'b0, 1'b0);
        return;
      end
      l = sel ? line1 : line0;
      chk_out(sel, "frame", exp_bit(w, c / cpb, pe), 1'b0, 1'b1, 1'b0);
      if (c % cpb == cpb / 2 && c / cpb >= 1 && c / cpb <= 8) rx[c/cpb-1] = l;
      @(negedge clk);
    end
    chk_out(sel, "done", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rx_word", rx, w);
  endtask
  initial begin
    logic [7:0] w;
    repeat (3) begin
      @(negedge clk);
      chk_out(0, "reset0", 1'b1, 1'b1, 1'b0, 1'b0);
      chk_out(1, "reset1", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    reset = 0;
    @(negedge clk);
    chk_out(0, "idle0", 1'b1, 1'b1, 1'b0, 1'b0);
    frame(0, 8'hA5, 0, -1);
    @(negedge clk);
    chk_out(0, "post_done", 1'b1, 1'b1, 1'b0, 1'b0);
    frame(0, 8'h07, 0, -1);
    frame(0, 8'h3C, 1, -1);
    frame(0, 8'hC3, 0, -1);
    @(negedge clk);
    frame(0, 8'hFF, 0, 17);
    frame(0, 8'h5A, 0, -1);
    @(negedge clk);
    frame(1, 8'h80, 0, -1);
    @(negedge clk);
    chk_out(1, "idle1", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      frame(0, w, i != 3, -1);
    end
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      frame(1, w, i != 3, -1);
    end
    v0 = 0;
    v1 = 0;
    @(negedge clk);
    chk_out(0, "final0", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_out(1, "final1", 1'b1, 1'b1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
